// File: rtl/alu_exec_stage.sv
// Single-slot ALU execute stage: it registers one operation, captures the result
// from the external arithmetic unit and then holds it for the downstream handshake.
module alu_exec_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_a,
  input  logic [15:0]        in_b,
  input  logic [1:0]         in_op,
  output logic [15:0]        arith_a,
  output logic [15:0]        arith_b,
  output logic [1:0]         arith_op,
  input  logic [15:0]        arith_result,
  input  logic               arith_carry,
  input  logic               arith_overflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_result,
  output logic               out_carry,
  output logic               out_overflow,
  output logic               out_divzero,
  output logic               sticky_ovf,
  input  logic               clear_sticky,
  output logic [COUNT_W-1:0] op_count
);

  // state  | meaning
  // S_IDLE | ready for a new operation
  // S_EXEC | operands are at the arithmetic unit; capture its result this cycle
  // S_DONE | result is presented and held until downstream takes it
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [15:0]        arith_a_q, arith_a_d;
  logic [15:0]        arith_b_q, arith_b_d;
  logic [1:0]         arith_op_q, arith_op_d;
  logic [15:0]        result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               divzero_q, divzero_d;
  logic               sticky_q, sticky_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic accept;
  logic capture;
  logic consume;
  logic divzero_now;

  assign accept      = (state_q == S_IDLE) && in_valid;
  assign capture     = (state_q == S_EXEC);
  assign consume     = (state_q == S_DONE) && out_ready;
  assign divzero_now = (arith_op_q == 2'b11) && (arith_b_q == 16'h0000);

  always_comb begin
    state_d    = state_q;
    arith_a_d  = arith_a_q;
    arith_b_d  = arith_b_q;
    arith_op_d = arith_op_q;
    result_d   = result_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    divzero_d  = divzero_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          arith_a_d  = in_a;
          arith_b_d  = in_b;
          arith_op_d = in_op;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d  = arith_result;
        carry_d   = arith_carry;
        ovf_d     = arith_overflow;
        divzero_d = divzero_now;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (consume) begin
          count_d = count_q + COUNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A flag raised by this cycle's capture outranks a concurrent clear request.
  always_comb begin
    sticky_d = sticky_q;
    if (capture && (arith_overflow || divzero_now)) begin
      sticky_d = 1'b1;
    end else if (clear_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      arith_a_q  <= '0;
      arith_b_q  <= '0;
      arith_op_q <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      divzero_q  <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      arith_a_q  <= arith_a_d;
      arith_b_q  <= arith_b_d;
      arith_op_q <= arith_op_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      divzero_q  <= divzero_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign arith_a      = arith_a_q;
  assign arith_b      = arith_b_q;
  assign arith_op     = arith_op_q;
  assign out_result   = result_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
  assign out_divzero  = divzero_q;
  assign sticky_ovf   = sticky_q;
  assign op_count     = count_q;

endmodule
